dcache_ctrl: RTL
================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data-cache controller in the MEM stage.
//  Serves CPU loads/stores (MemRead/MemWrite from decode) and freezes the pipeline via cpu_stall_o on a miss.
//  Sequences line write-back and refill against a slow off-chip data memory over a req/ack handshake.
// PARAMETERS
//  ADDR_W     32   byte-address width
//  LINE_W     256  line width in bits (8 words); OFF_W = log2(LINE_W/8) = 5
//  NUM_LINES  16   number of lines; IDX_W = 4, TAG_W = ADDR_W-IDX_W-OFF_W = 23
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_i        in   1       async active-high reset
//  cpu_req_i    in   1       MemRead_o | MemWrite_o of the instruction in MEM
//  cpu_we_i     in   1       1 = store, 0 = load
//  cpu_addr_i   in   ADDR_W  byte address (ALU result)
//  cpu_data_i   in   32      store data
//  cpu_data_o   out  32      load data, valid when cpu_req_i & !cpu_stall_o
//  cpu_stall_o  out  1       freeze PC/IF/ID/EX/MEM registers
//  mem_req_o    out  1       off-chip request
//  mem_we_o     out  1       1 = line write-back, 0 = line fetch
//  mem_addr_o   out  ADDR_W  line-aligned address (low OFF_W bits 0)
//  mem_data_o   out  LINE_W  victim line for write-back
//  mem_data_i   in   LINE_W  refill line
//  mem_ack_i    in   1       one-cycle completion pulse from memory
// BEHAVIOUR
//  Reset: state IDLE; all valid/dirty bits 0; mem_req_o, mem_we_o, cpu_stall_o 0; mem_addr_o, mem_data_o, cpu_data_o 0.
//   Reset mid-transaction: request dropped immediately (async); memory must tolerate the abort.
//  Address split: tag=addr[ADDR_W-1:9], index=addr[8:5], word=addr[4:2]; addr[1:0] ignored (word accesses only).
//  hit = cpu_req_i & valid[index] & (tag_arr[index]==tag); evaluated combinationally in IDLE only.
//  IDLE: no req -> stall 0. Hit load: cpu_data_o = line[word] same cycle, stall 0.
//   Hit store: word written and dirty set at next edge, stall 0.
//   Miss: cpu_stall_o=1 same cycle; next state WRITEBACK if valid&dirty victim, else ALLOCATE.
//  WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag,index,0}, mem_data_o=victim line; on mem_ack_i -> ALLOCATE.
//  ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag,index,0}; on mem_ack_i capture mem_data_i -> FILL.
//  FILL: write line, tag; valid=1, dirty=0; -> IDLE, where the held access re-evaluates as a hit (store then sets dirty).
//  cpu_stall_o = 1 in WRITEBACK, ALLOCATE, FILL, and in IDLE on miss.
//  Handshake: mem_req_o/mem_we_o/mem_addr_o/mem_data_o driven from registered state and stable until the ack edge;
//   mem_ack_i with mem_req_o=0 ignored; ack in the cycle req rises is legal (zero extra wait).
//  Latency: clean miss detected cycle 0 -> req cycles 1..k (ack at k) -> FILL k+1 -> hit served k+2.
//   Dirty miss adds the write-back req/ack span before ALLOCATE.
//  CPU contract: cpu_req_i/we/addr/data held stable while stall=1; if cpu_req_i drops mid-miss, the fill still completes.
//  Index/tag collision: store-miss to a dirty line always writes the old victim back before refill.
// STRUCTURE
//  Shared header dcache_defs.vh: state encodings (IDLE, WRITEBACK, ALLOCATE, FILL), OFF_W/IDX_W/TAG_W derivation, word-select macros.
//  One sub-module dcache_array: tag/valid/dirty/data storage, async read, single sync write port (line or word),
//   async clear of valid/dirty on rst_i. FSM, hit logic and handshake stay in dcache_ctrl.
// TESTING
//  1 Cold load 0x0000_0040, memory ack 3 cycles after req -> stall high cycles 0..4,
//    mem_addr_o=0x40, mem_we_o=0, load data returned cycle 5.
//  2 Store 0xDEADBEEF to 0x44 after test 1 -> no stall; subsequent load 0x44 returns 0xDEADBEEF, dirty[2]=1.
//  3 Load 0x0000_0240 (same index 2, new tag) -> write-back first: mem_we_o=1, mem_addr_o=0x40, word1=0xDEADBEEF;
//    then fetch 0x240.
//  4 Store miss to clean line 0x1000 -> single ALLOCATE fetch of 0x1000, write applied after FILL, no write-back.
//  5 Assert rst_i while in ALLOCATE with req high -> mem_req_o and cpu_stall_o fall same cycle;
//    next access to that address misses again.
//  6 Spurious mem_ack_i while IDLE; ack in first req cycle -> no state change / FILL next cycle respectively.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the L1 data-cache controller: default geometry,
// controller states and the address-split width helper.
package dcache_ctrl_pkg;

    localparam int DC_ADDR_W    = 32;
    localparam int DC_LINE_W    = 256;
    localparam int DC_NUM_LINES = 16;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        FILL      = 2'd3
    } dcState_t;

    // Byte-offset width of a line; the word select is this minus the 2 byte bits.
    function automatic int offW(input int lineW);
        return $clog2(lineW / 8);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: asynchronous read,
// one synchronous write port that either refills a whole line or updates one word.
module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int LINE_W    = DC_LINE_W,
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 23,
    parameter int WSEL_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic              rdValid,
    output logic              rdDirty,
    output logic [TAG_W-1:0]  rdTag,
    output logic [LINE_W-1:0] rdLine,
    input  logic              wrEn,
    input  logic              wrFull,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [TAG_W-1:0]  wrTag,
    input  logic [LINE_W-1:0] wrLine,
    input  logic [WSEL_W-1:0] wrWord,
    input  logic [WORD_W-1:0] wrData
);

    logic [NUM_LINES-1:0] validArr;
    logic [NUM_LINES-1:0] dirtyArr;
    logic [TAG_W-1:0]     tagArr  [NUM_LINES];
    logic [LINE_W-1:0]    dataArr [NUM_LINES];

    assign rdValid = validArr[rdIdx];
    assign rdDirty = dirtyArr[rdIdx];
    assign rdTag   = tagArr[rdIdx];
    assign rdLine  = dataArr[rdIdx];

    // Only the state bits are reset; tag/data contents are meaningless while invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            validArr <= '0;
            dirtyArr <= '0;
        end else if (wrEn) begin
            if (wrFull) begin
                validArr[wrIdx] <= 1'b1;
                dirtyArr[wrIdx] <= 1'b0;
            end else begin
                dirtyArr[wrIdx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            if (wrFull) begin
                tagArr[wrIdx]  <= wrTag;
                dataArr[wrIdx] <= wrLine;
            end else begin
                dataArr[wrIdx][wrWord*WORD_W +: WORD_W] <= wrData;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit path in IDLE,
// miss sequencing through WRITEBACK/ALLOCATE/FILL against a req/ack line memory.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DC_ADDR_W,
    parameter int LINE_W    = DC_LINE_W,
    parameter int NUM_LINES = DC_NUM_LINES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int OFF_W  = offW(LINE_W);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;

    dcState_t state, stateNext;

    logic [TAG_W-1:0]  cpuTag, missTag, rdTag;
    logic [IDX_W-1:0]  cpuIdx, missIdx;
    logic [WSEL_W-1:0] cpuWord;
    logic              rdValid, rdDirty, hit, stall, arrWe, arrFull;
    logic [LINE_W-1:0] rdLine, fillBuf, memData;
    logic [ADDR_W-1:0] memAddr;
    logic [1:0]        unusedByteSel;

    assign cpuTag        = cpu_addr_i[ADDR_W-1:OFF_W+IDX_W];
    assign cpuIdx        = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign cpuWord       = cpu_addr_i[OFF_W-1:2];
    assign unusedByteSel = cpu_addr_i[1:0];

    dcache_array #(
        .LINE_W   (LINE_W),
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .WSEL_W   (WSEL_W)
    ) uArray (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rdIdx  (cpuIdx),
        .rdValid(rdValid),
        .rdDirty(rdDirty),
        .rdTag  (rdTag),
        .rdLine (rdLine),
        .wrEn   (arrWe),
        .wrFull (arrFull),
        .wrIdx  (arrFull ? missIdx : cpuIdx),
        .wrTag  (missTag),
        .wrLine (fillBuf),
        .wrWord (cpuWord),
        .wrData (cpu_data_i)
    );

    assign hit = cpu_req_i && (state == IDLE) && rdValid && (rdTag == cpuTag);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        arrWe     = 1'b0;
        arrFull   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    stall     = 1'b1;
                    stateNext = (rdValid && rdDirty) ? WRITEBACK : ALLOCATE;
                end else if (hit && cpu_we_i) begin
                    arrWe = 1'b1;
                end
            end
            WRITEBACK: begin
                stall = 1'b1;
                if (mem_ack_i) stateNext = ALLOCATE;
            end
            ALLOCATE: begin
                stall = 1'b1;
                if (mem_ack_i) stateNext = FILL;
            end
            FILL: begin
                stall     = 1'b1;
                arrWe     = 1'b1;
                arrFull   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Miss line address is latched so the refill completes even if the CPU drops its request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            missTag <= '0;
            missIdx <= '0;
            memAddr <= '0;
            memData <= '0;
            fillBuf <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_req_i && !hit) begin
                    missTag <= cpuTag;
                    missIdx <= cpuIdx;
                    if (rdValid && rdDirty) begin
                        memAddr <= {rdTag, cpuIdx, {OFF_W{1'b0}}};
                        memData <= rdLine;
                    end else begin
                        memAddr <= {cpuTag, cpuIdx, {OFF_W{1'b0}}};
                    end
                end
                WRITEBACK: if (mem_ack_i) memAddr <= {missTag, missIdx, {OFF_W{1'b0}}};
                ALLOCATE:  if (mem_ack_i) fillBuf <= mem_data_i;
                default: ;
            endcase
        end
    end

    assign mem_req_o   = (state == WRITEBACK) || (state == ALLOCATE);
    assign mem_we_o    = (state == WRITEBACK);
    assign mem_addr_o  = memAddr;
    assign mem_data_o  = memData;
    assign cpu_stall_o = stall && !rst_i;
    assign cpu_data_o  = (hit && !cpu_we_i) ? rdLine[cpuWord*WORD_W +: WORD_W] : '0;

endmodule
